radar_pulse_tx: RTL and testbench

RADAR_PULSE_TX -- requirements
Module: radar_pulse_tx

---
 rtl/radar_pulse_tx_if.sv | 22 ++
 rtl/radar_pulse_tx.sv | 117 +++++++++++
 tb/tb_radar_pulse_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/radar_pulse_tx_if.sv
// Handshake and status bundle between the radar pulse transmitter and its consumer.
// The slave modport is the transmitter side; master is the controller/consumer side.
interface radar_pulse_tx_if;
    logic       start;
    logic       stop;
    logic       ready;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       tx_active;
    logic [7:0] pulse_cnt;
    logic       burst_done;

    modport slave (
        input  start, stop, ready,
        output sample_out, sample_valid, tx_active, pulse_cnt, burst_done
    );

    modport master (
        output start, stop, ready,
        input  sample_out, sample_valid, tx_active, pulse_cnt, burst_done
    );
endinterface

// File: rtl/radar_pulse_tx.sv
// Pulsed radar transmitter: PULSE_LEN samples of AMP then silence up to PRI, repeated until stopped.
// Optional macro PULSE_TX_TAPER_EN halves the first and last sample of each pulse.
module radar_pulse_tx #(
    parameter int         PULSE_LEN = 8,
    parameter int         PRI       = 32,
    parameter logic [7:0] AMP       = 8'd100
) (
    input logic            clk,
    input logic            rst,
    radar_pulse_tx_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_LISTEN} state_t;

    localparam logic [7:0] LAST_PULSE = 8'(PULSE_LEN - 1);
    localparam logic [7:0] LAST_PRI   = 8'(PRI - 1);
`ifdef PULSE_TX_TAPER_EN
    localparam logic [7:0] EDGE_AMP = AMP >> 1;
`else
    localparam logic [7:0] EDGE_AMP = AMP;
`endif

    state_t     r_state;
    logic [7:0] r_idx;
    logic       r_stop_latch;
    logic [7:0] r_sample_out;
    logic       r_sample_valid;
    logic       r_tx_active;
    logic [7:0] r_pulse_cnt;
    logic       r_burst_done;

    logic w_accept;
    assign w_accept = r_sample_valid && bus.ready;

    function automatic logic [7:0] amp_at(input logic [7:0] idx);
        return (idx == 8'd0 || idx == LAST_PULSE) ? EDGE_AMP : AMP;
    endfunction

    // Outputs are loaded together with the state they belong to, so every
    // output reflects the sample at the current idx without any decode logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 8'd0;
            r_stop_latch   <= 1'b0;
            r_sample_out   <= 8'd0;
            r_sample_valid <= 1'b0;
            r_tx_active    <= 1'b0;
            r_pulse_cnt    <= 8'd0;
            r_burst_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch reads the pre-edge values.
            r_burst_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state        <= S_PULSE;
                        r_idx          <= 8'd0;
                        r_pulse_cnt    <= 8'd0;
                        r_stop_latch   <= bus.stop;
                        r_sample_out   <= amp_at(8'd0);
                        r_sample_valid <= 1'b1;
                        r_tx_active    <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (bus.stop) r_stop_latch <= 1'b1;
                    if (w_accept) begin
                        r_idx <= r_idx + 8'd1;
                        if (r_idx == LAST_PULSE) begin
                            r_state      <= S_LISTEN;
                            r_sample_out <= 8'd0;
                            r_tx_active  <= 1'b0;
                        end else begin
                            r_sample_out <= amp_at(r_idx + 8'd1);
                        end
                    end
                end
                S_LISTEN: begin
                    if (bus.stop) r_stop_latch <= 1'b1;
                    if (w_accept) begin
                        if (r_idx == LAST_PRI) begin
                            r_idx       <= 8'd0;
                            r_pulse_cnt <= r_pulse_cnt + 8'd1;
                            // A stop on the very last sample still ends the train here.
                            if (r_stop_latch || bus.stop) begin
                                r_state        <= S_IDLE;
                                r_stop_latch   <= 1'b0;
                                r_sample_valid <= 1'b0;
                                r_burst_done   <= 1'b1;
                            end else begin
                                r_state      <= S_PULSE;
                                r_sample_out <= amp_at(8'd0);
                                r_tx_active  <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_idx          <= 8'd0;
                    r_stop_latch   <= 1'b0;
                    r_sample_out   <= 8'd0;
                    r_sample_valid <= 1'b0;
                    r_tx_active    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;
    assign bus.tx_active    = r_tx_active;
    assign bus.pulse_cnt    = r_pulse_cnt;
    assign bus.burst_done   = r_burst_done;
endmodule

// File: tb/tb_radar_pulse_tx.sv
// Directed bench for radar_pulse_tx at default parameters: vector table plus
// multi-cycle sequences for full trains, ready stalls, start+stop and mid-pulse reset.
module tb_radar_pulse_tx;
    localparam logic [7:0] AMP = 8'd100;
`ifdef PULSE_TX_TAPER_EN
    localparam logic [7:0] EDGE = 8'd50;
`else
    localparam logic [7:0] EDGE = 8'd100;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    radar_pulse_tx_if bus ();

    radar_pulse_tx #(.PULSE_LEN(8), .PRI(32), .AMP(AMP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       ready;
        logic [7:0] e_out;
        logic       e_valid;
        logic       e_tx;
        logic [7:0] e_cnt;
        logic       e_done;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eo, input logic ev,
                              input logic et, input logic [7:0] ec, input logic ed);
        check({tag, ".sample_out"},   32'(bus.sample_out),   32'(eo));
        check({tag, ".sample_valid"}, 32'(bus.sample_valid), 32'(ev));
        check({tag, ".tx_active"},    32'(bus.tx_active),    32'(et));
        check({tag, ".pulse_cnt"},    32'(bus.pulse_cnt),    32'(ec));
        check({tag, ".burst_done"},   32'(bus.burst_done),   32'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_amp(input int i);
        if (i >= 8) return 8'd0;
        if (i == 0 || i == 7) return EDGE;
        return AMP;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         tx_cycles;
        int         done_seen;
        int         cycles;
        int         acc_n;
        int         acc_hi;
        logic [7:0] p_out;
        logic       p_valid;
        logic       p_tx;
        logic       r_now;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, EDGE, 1'b1, 1'b1, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, EDGE, 1'b1, 1'b1, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, AMP,  1'b1, 1'b1, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, EDGE, 1'b1, 1'b1, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0};

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ready = 1'b1;
        #22;
        check_outs("reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Table: stop ignored in IDLE, start, ready stalls, start ignored mid-pulse.
        for (int i = 0; i < 12; i++) begin
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            bus.ready = vecs[i].ready;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                       vecs[i].e_tx, vecs[i].e_cnt, vecs[i].e_done);
        end

        // Finish that PRI; a stall on idx 31, then stop on the last accepted sample.
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ready = 1'b1;
        for (int i = 9; i <= 31; i++) begin
            step();
            check_outs($sformatf("listen%0d", i), 8'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        end
        bus.ready = 1'b0;
        step();
        check_outs("stall_idx31", 8'd0, 1'b1, 1'b0, 8'd0, 1'b0);
        bus.ready = 1'b1;
        bus.stop  = 1'b1;
        step();
        check_outs("stop_at_end", 8'd0, 1'b0, 1'b0, 8'd1, 1'b1);
        bus.stop = 1'b0;
        step();
        check_outs("after_done", 8'd0, 1'b0, 1'b0, 8'd1, 1'b0);

        // Two-PRI train, stop at cycle 40, repeated start mid-train.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tx_cycles = 0;
        done_seen = 0;
        check_outs("trainB_k0", exp_amp(0), 1'b1, 1'b1, 8'd0, 1'b0);
        if (bus.tx_active) tx_cycles++;
        for (k = 1; k < 64; k++) begin
            bus.stop  = (k == 40);
            bus.start = (k == 10 || k == 50);
            step();
            check_outs($sformatf("trainB_k%0d", k), exp_amp(k % 32), 1'b1,
                       (k % 32) < 8, 8'(k / 32), 1'b0);
            if (bus.tx_active) tx_cycles++;
            if (bus.burst_done) done_seen++;
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        step();
        check_outs("trainB_end", 8'd0, 1'b0, 1'b0, 8'd2, 1'b1);
        check("trainB_tx_cycles", 32'(tx_cycles), 32'd16);
        check("trainB_early_done", 32'(done_seen), 32'd0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check_outs("idle_stop_ignored", 8'd0, 1'b0, 1'b0, 8'd2, 1'b0);

        // start+stop together, ready toggling: one PRI over 64 cycles.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.ready = 1'b0;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_outs("trainC_k0", exp_amp(0), 1'b1, 1'b1, 8'd0, 1'b0);
        cycles = 0;
        acc_n  = 0;
        acc_hi = 0;
        while (cycles < 200) begin
            r_now     = (cycles % 2) == 1;
            bus.ready = r_now;
            if (r_now && bus.sample_valid) begin
                check($sformatf("trainC_sample%0d", acc_n), 32'(bus.sample_out), 32'(exp_amp(acc_n)));
                if (bus.tx_active) acc_hi++;
                acc_n++;
            end
            p_out   = bus.sample_out;
            p_valid = bus.sample_valid;
            p_tx    = bus.tx_active;
            step();
            cycles++;
            if (!r_now) begin
                check("trainC_hold_out",   32'(bus.sample_out),   32'(p_out));
                check("trainC_hold_valid", 32'(bus.sample_valid), 32'(p_valid));
                check("trainC_hold_tx",    32'(bus.tx_active),    32'(p_tx));
            end
            if (bus.burst_done) break;
        end
        check("trainC_cycles", 32'(cycles), 32'd64);
        check("trainC_accepted", 32'(acc_n), 32'd32);
        check("trainC_pulse_samples", 32'(acc_hi), 32'd8);
        check_outs("trainC_end", 8'd0, 1'b0, 1'b0, 8'd1, 1'b1);

        // Asynchronous reset at idx 3 of PULSE, then a clean restart.
        bus.ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check_outs("pre_reset_idx3", exp_amp(3), 1'b1, 1'b1, 8'd0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        check_outs("in_reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_outs("post_reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        bus.stop = 1'b1;
        step();
        bus.stop  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_outs($sformatf("restart_idx%0d", i), exp_amp(i), 1'b1, i < 8, 8'd0, 1'b0);
            step();
        end
        check_outs("restart_next_pri", exp_amp(0), 1'b1, 1'b1, 8'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
